// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst, response and state types for the AXI memory responder
package axi_pkg;

   typedef enum logic [1:0] {
      FIXED = 2'b00,
      INCR  = 2'b01,
      WRAP  = 2'b10
   } burst_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      R_WAIT,
      R_BURST,
      W_DATA,
      W_RESP
   } state_t;

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - combinational next-beat index and burst legality
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int IDX_W = 12
) (
   input  logic [IDX_W-1:0] idx,
   input  logic [7:0]       len,
   input  logic [1:0]       burst,
   output logic [IDX_W-1:0] next_idx,
   output logic             burst_err
);

   logic [IDX_W-1:0] mask;
   logic [IDX_W-1:0] inc;

   always_comb begin
      mask      = IDX_W'(len);
      inc       = idx + IDX_W'(1);
      next_idx  = idx;
      burst_err = 1'b0;
      case (burst)
         FIXED: next_idx = idx;
         INCR:  next_idx = inc;
         WRAP: begin
            // len+1 is a power of two for legal wraps, so len is the in-block mask
            next_idx  = (idx & ~mask) | (inc & mask);
            burst_err = !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
         end
         default: burst_err = 1'b1;
      endcase
   end

endmodule

// File: rtl/axi_mem_responder.sv
// rtl/axi_mem_responder.sv - single-outstanding AXI slave backed by an internal beat memory
module axi_mem_responder
   import axi_pkg::*;
#(
   parameter int DATA_WIDTH    = 64,
   parameter int ADDR_WIDTH    = 64,
   parameter int MEM_WORDS_LOG = 12,
   parameter int READ_LATENCY  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   input  logic [7:0]            m_axi_awlen,
   input  logic [2:0]            m_axi_awsize,
   input  logic [1:0]            m_axi_awburst,
   input  logic                  m_axi_awlock,
   input  logic [3:0]            m_axi_awcache,
   input  logic [2:0]            m_axi_awprot,
   input  logic                  m_axi_awvalid,
   output logic                  m_axi_awready,
   input  logic [DATA_WIDTH-1:0] m_axi_wdata,
   input  logic                  m_axi_wlast,
   input  logic                  m_axi_wvalid,
   output logic                  m_axi_wready,
   output logic [1:0]            m_axi_bresp,
   output logic                  m_axi_bvalid,
   input  logic                  m_axi_bready,
   input  logic [ADDR_WIDTH-1:0] m_axi_araddr,
   input  logic [7:0]            m_axi_arlen,
   input  logic [2:0]            m_axi_arsize,
   input  logic [1:0]            m_axi_arburst,
   input  logic                  m_axi_arlock,
   input  logic [3:0]            m_axi_arcache,
   input  logic [2:0]            m_axi_arprot,
   input  logic                  m_axi_arvalid,
   output logic                  m_axi_arready,
   output logic [DATA_WIDTH-1:0] m_axi_rdata,
   output logic [1:0]            m_axi_rresp,
   output logic                  m_axi_rlast,
   output logic                  m_axi_rvalid,
   input  logic                  m_axi_rready,
   output logic                  m_axi_acvalid,
   output logic [ADDR_WIDTH-1:0] m_axi_acaddr,
   output logic [3:0]            m_axi_acsnoop,
   input  logic                  m_axi_acready
);

   localparam int SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int IDX_W = MEM_WORDS_LOG;

   state_t                  state, state_nx;
   logic [IDX_W-1:0]        idx, idx_nx;
   logic [7:0]              len, beat_cnt, lat_cnt;
   logic [1:0]              burst, bresp_q, beat_resp;
   logic                    decerr, over, burst_err;
   logic                    aw_hs, ar_hs, w_hs, r_hs, start_oor;
   logic [ADDR_WIDTH-1:0]   ax_addr;
   logic [7:0]              ax_len;
   logic [1:0]              ax_burst;
   logic [DATA_WIDTH-1:0]   mem [0:(1<<MEM_WORDS_LOG)-1];
   logic                    unused_inputs;

   assign unused_inputs = ^{m_axi_awsize, m_axi_arsize, m_axi_awlock, m_axi_awcache,
                            m_axi_awprot, m_axi_arlock, m_axi_arcache, m_axi_arprot,
                            m_axi_acready, ax_addr[SHIFT-1:0]};

   assign m_axi_acvalid = 1'b0;
   assign m_axi_acaddr  = '0;
   assign m_axi_acsnoop = '0;

   assign aw_hs    = m_axi_awvalid && m_axi_awready;
   assign ar_hs    = m_axi_arvalid && m_axi_arready;
   assign w_hs     = m_axi_wvalid && m_axi_wready;
   assign r_hs     = m_axi_rvalid && m_axi_rready;
   assign ax_addr  = aw_hs ? m_axi_awaddr  : m_axi_araddr;
   assign ax_len   = aw_hs ? m_axi_awlen   : m_axi_arlen;
   assign ax_burst = aw_hs ? m_axi_awburst : m_axi_arburst;
   assign start_oor = |ax_addr[ADDR_WIDTH-1:SHIFT+IDX_W];

   axi_burst_addr #(.IDX_W(IDX_W)) u_burst_addr (
      .idx       (idx),
      .len       (len),
      .burst     (burst),
      .next_idx  (idx_nx),
      .burst_err (burst_err)
   );

   assign beat_resp   = decerr ? DECERR : (burst_err ? SLVERR : OKAY);
   assign m_axi_rlast = (state == R_BURST) && (beat_cnt == len);
   assign m_axi_rresp = (state == R_BURST) ? beat_resp : OKAY;
   assign m_axi_rdata = (state == R_BURST && beat_resp == OKAY) ? mem[idx] : '0;
   assign m_axi_bresp = (state == W_RESP) ? bresp_q : OKAY;

   always_comb begin
      state_nx      = state;
      m_axi_awready = 1'b0;
      m_axi_arready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_rvalid  = 1'b0;
      m_axi_bvalid  = 1'b0;
      case (state)
         IDLE: begin
            // reset gates the readies so every output is 0 while held in reset
            m_axi_awready = reset;
            m_axi_arready = reset && !m_axi_awvalid;
            if (aw_hs)
               state_nx = W_DATA;
            else if (ar_hs)
               state_nx = (READ_LATENCY == 1) ? R_BURST : R_WAIT;
         end
         R_WAIT: begin
            if (lat_cnt == 8'(READ_LATENCY - 2))
               state_nx = R_BURST;
         end
         R_BURST: begin
            m_axi_rvalid = 1'b1;
            if (m_axi_rready && m_axi_rlast)
               state_nx = IDLE;
         end
         W_DATA: begin
            m_axi_wready = 1'b1;
            if (m_axi_wvalid && m_axi_wlast)
               state_nx = W_RESP;
         end
         W_RESP: begin
            m_axi_bvalid = 1'b1;
            if (m_axi_bready)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         idx      <= '0;
         len      <= '0;
         burst    <= '0;
         beat_cnt <= '0;
         lat_cnt  <= '0;
         decerr   <= 1'b0;
         over     <= 1'b0;
         bresp_q  <= OKAY;
      end else begin
         state <= state_nx;
         if (aw_hs || ar_hs) begin
            idx      <= ax_addr[SHIFT +: IDX_W];
            len      <= ax_len;
            burst    <= ax_burst;
            beat_cnt <= '0;
            lat_cnt  <= '0;
            decerr   <= start_oor;
            over     <= 1'b0;
         end
         if (state == R_WAIT)
            lat_cnt <= lat_cnt + 8'd1;
         if (r_hs) begin
            idx      <= idx_nx;
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (w_hs) begin
            // once beat len is taken, further beats are swallowed until wlast
            if (!over) begin
               idx <= idx_nx;
               if (beat_cnt == len)
                  over <= 1'b1;
               else
                  beat_cnt <= beat_cnt + 8'd1;
            end
            if (m_axi_wlast)
               bresp_q <= (over || beat_cnt != len) ? SLVERR : beat_resp;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_hs && !over && beat_resp == OKAY)
         mem[idx] <= m_axi_wdata;
   end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb/tb_axi_mem_responder.sv - randomized and directed self-checking bench for axi_mem_responder
module tb_axi_mem_responder;

   localparam int DW    = 64;
   localparam int AW    = 64;
   localparam int MWL   = 12;
   localparam int RL    = 2;
   localparam int DEPTH = 1 << MWL;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] m_axi_awaddr = '0, m_axi_araddr = '0, m_axi_acaddr;
   logic [7:0]    m_axi_awlen = '0, m_axi_arlen = '0;
   logic [2:0]    m_axi_awsize = '0, m_axi_arsize = '0, m_axi_awprot = '0, m_axi_arprot = '0;
   logic [1:0]    m_axi_awburst = '0, m_axi_arburst = '0, m_axi_bresp, m_axi_rresp;
   logic [3:0]    m_axi_awcache = '0, m_axi_arcache = '0, m_axi_acsnoop;
   logic          m_axi_awlock = 1'b0, m_axi_arlock = 1'b0;
   logic          m_axi_awvalid = 1'b0, m_axi_arvalid = 1'b0, m_axi_wvalid = 1'b0;
   logic          m_axi_wlast = 1'b0, m_axi_bready = 1'b0, m_axi_rready = 1'b1;
   logic          m_axi_acready = 1'b0;
   logic          m_axi_awready, m_axi_arready, m_axi_wready, m_axi_bvalid;
   logic          m_axi_rlast, m_axi_rvalid, m_axi_acvalid;
   logic [DW-1:0] m_axi_wdata = '0, m_axi_rdata;

   always #5 clk = ~clk;

   axi_mem_responder #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS_LOG(MWL), .READ_LATENCY(RL)
   ) dut (
      .clk(clk), .reset(reset),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
      .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock), .m_axi_awcache(m_axi_awcache),
      .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
      .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
      .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .m_axi_acvalid(m_axi_acvalid), .m_axi_acaddr(m_axi_acaddr), .m_axi_acsnoop(m_axi_acsnoop),
      .m_axi_acready(m_axi_acready)
   );

   int          n_compared = 0;
   int          n_mismatched = 0;
   int          last_ar_wait;
   logic [63:0] mdl [DEPTH];
   logic [63:0] rx_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // reference rules: beat index = byte address / 8, wraps computed arithmetically
   function automatic bit addr_oor(input logic [63:0] a);
      return (a >> 3) >= 64'(DEPTH);
   endfunction

   function automatic bit burst_bad(input int len, input int burst);
      if (burst == 3) return 1'b1;
      if (burst == 2) return !(len == 1 || len == 3 || len == 7 || len == 15);
      return 1'b0;
   endfunction

   function automatic int beat_idx(input logic [63:0] a, input int len, input int burst, input int i);
      int s, n;
      s = int'(a >> 3);
      n = len + 1;
      if (burst == 0) return s % DEPTH;
      if (burst == 1) return (s + i) % DEPTH;
      return (s - (s % n) + ((s % n) + i) % n) % DEPTH;
   endfunction

   task automatic do_write(input logic [63:0] a, input int len, input int burst, input logic [63:0] d[$]);
      int t, nb;
      logic [1:0] exp_b;
      nb = d.size();
      m_axi_awaddr = a; m_axi_awlen = 8'(len); m_axi_awburst = 2'(burst);
      m_axi_awsize = 3'($urandom); m_axi_awvalid = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!m_axi_awready && t < 50);
      check("awready", m_axi_awready, 1);
      if (m_axi_arvalid) check("aw_wins_arready", m_axi_arready, 0);
      @(posedge clk); #1;
      m_axi_awvalid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         m_axi_wdata = d[i]; m_axi_wlast = (i == nb - 1); m_axi_wvalid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!m_axi_wready && t < 50);
         check("wready", m_axi_wready, 1);
         @(posedge clk); #1;
      end
      m_axi_wvalid = 1'b0; m_axi_wlast = 1'b0; m_axi_bready = 1'b1;
      t = 0;
      do begin @(negedge clk); t++; end while (!m_axi_bvalid && t < 50);
      check("bvalid", m_axi_bvalid, 1);
      exp_b = (nb != len + 1) ? 2'b10 : addr_oor(a) ? 2'b11 : burst_bad(len, burst) ? 2'b10 : 2'b00;
      check("bresp", m_axi_bresp, exp_b);
      if (m_axi_arvalid) check("ar_held_during_b", m_axi_arready, 0);
      @(posedge clk); #1;
      m_axi_bready = 1'b0;
      if (!addr_oor(a) && !burst_bad(len, burst))
         for (int i = 0; i < nb && i <= len; i++) mdl[beat_idx(a, len, burst, i)] = d[i];
   endtask

   task automatic ar_issue(input logic [63:0] a, input int len, input int burst);
      m_axi_araddr = a; m_axi_arlen = 8'(len); m_axi_arburst = 2'(burst);
      m_axi_arsize = 3'($urandom); m_axi_arvalid = 1'b1;
      last_ar_wait = 0;
      do begin @(negedge clk); last_ar_wait++; end while (!m_axi_arready && last_ar_wait < 50);
      check("arready", m_axi_arready, 1);
      @(posedge clk); #1;
      m_axi_arvalid = 1'b0;
   endtask

   task automatic do_read(input logic [63:0] a, input int len, input int burst,
                          input int stall_at, input int abort_at);
      int k, t;
      bit err;
      logic [63:0] exp_d;
      logic [1:0]  exp_r;
      err   = addr_oor(a) || burst_bad(len, burst);
      exp_r = addr_oor(a) ? 2'b11 : burst_bad(len, burst) ? 2'b10 : 2'b00;
      rx_q  = {};
      ar_issue(a, len, burst);
      k = 1;
      @(negedge clk);
      while (!m_axi_rvalid && k < 50) begin @(negedge clk); k++; end
      check("rd_latency", k, RL);
      for (int i = 0; i <= len; i++) begin
         t = 0;
         while (!m_axi_rvalid && t < 50) begin @(negedge clk); t++; end
         check("rvalid", m_axi_rvalid, 1);
         exp_d = err ? 64'd0 : mdl[beat_idx(a, len, burst, i)];
         if (i == abort_at) begin
            #1 reset = 1'b0;
            #1 check("rst_rvalid", m_axi_rvalid, 0);
            check("rst_arready", m_axi_arready, 0);
            @(posedge clk); #1 reset = 1'b1;
            @(negedge clk);
            check("post_rst_arready", m_axi_arready, 1);
            repeat (3) begin
               check("no_stale_rvalid", m_axi_rvalid, 0);
               @(negedge clk);
            end
            @(posedge clk); #1;
            return;
         end
         if (i == stall_at) begin
            m_axi_rready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_rvalid", m_axi_rvalid, 1);
               check("stall_rdata", m_axi_rdata, exp_d);
               check("stall_rlast", m_axi_rlast, i == len);
            end
            m_axi_rready = 1'b1;
         end
         check($sformatf("rdata[%0d]", i), m_axi_rdata, exp_d);
         check($sformatf("rresp[%0d]", i), m_axi_rresp, exp_r);
         check($sformatf("rlast[%0d]", i), m_axi_rlast, i == len);
         rx_q.push_back(m_axi_rdata);
         @(posedge clk); #1;
         if (i < len) @(negedge clk);
      end
      @(negedge clk);
      check("rvalid_after_last", m_axi_rvalid, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] d [$];
      logic [63:0] v;
      int wrap_idx [8] = '{9, 10, 11, 12, 13, 14, 15, 8};
      int len, burst, stall;
      logic [63:0] a;

      repeat (3) @(negedge clk);
      check("rst_awready", m_axi_awready, 0);
      check("rst_arready", m_axi_arready, 0);
      check("rst_wready", m_axi_wready, 0);
      check("rst_rvalid", m_axi_rvalid, 0);
      check("rst_bvalid", m_axi_bvalid, 0);
      check("rst_snoop", {m_axi_acvalid, m_axi_acsnoop, m_axi_acaddr[3:0]}, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("idle_awready", m_axi_awready, 1);
      check("idle_arready", m_axi_arready, 1);
      @(posedge clk); #1;

      // fill memory; low 16 bits of each word hold its own beat index
      for (int k = 0; k < DEPTH / 256; k++) begin
         d = {};
         for (int j = 0; j < 256; j++) d.push_back({32'($urandom), 16'($urandom), 16'(k * 256 + j)});
         do_write(64'(k * 256 * 8), 255, 1, d);
      end

      do_read(64'h48, 7, 2, -1, -1);
      check("wrap_beats", rx_q.size(), 8);
      for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
         v = rx_q[i];
         check($sformatf("wrap_order[%0d]", i), v[15:0], wrap_idx[i]);
      end

      d = {64'hA0, 64'hA1, 64'hA2, 64'hA3};
      do_write(64'h100, 3, 1, d);
      do_read(64'h100, 3, 1, -1, -1);
      for (int i = 0; i < 4 && i < rx_q.size(); i++) check("incr_rdback", rx_q[i], 64'hA0 + 64'(i));

      m_axi_araddr = 64'h200; m_axi_arlen = 8'd1; m_axi_arburst = 2'd1; m_axi_arvalid = 1'b1;
      d = {64'hB0, 64'hB1};
      do_write(64'h200, 1, 1, d);
      do_read(64'h200, 1, 1, -1, -1);
      check("ar_after_b_wait", last_ar_wait, 1);

      do_read(64'h300, 7, 1, 3, -1);

      d = {64'hC0, 64'hC1, 64'hC2};
      do_write(64'h400, 7, 1, d);
      do_read(64'h400, 7, 1, -1, -1);
      do_read(64'h8000, 7, 1, -1, -1);

      do_read(64'h500, 7, 1, -1, 3);
      do_read(64'h500, 7, 1, -1, -1);

      do_read(64'(4094 * 8), 3, 1, -1, -1);
      d = {64'hD0, 64'hD1, 64'hD2, 64'hD3};
      do_write(64'h600, 1, 1, d);
      do_read(64'h600, 3, 1, -1, -1);
      d = {64'hE0, 64'hE1, 64'hE2};
      do_write(64'h700, 2, 2, d);
      do_read(64'h700, 2, 1, -1, -1);
      do_read(64'h700, 3, 3, -1, -1);
      d = {64'hF0, 64'hF1, 64'hF2};
      do_write(64'h800, 2, 0, d);
      do_read(64'h800, 1, 0, -1, -1);

      for (int it = 0; it < 40; it++) begin
         burst = $urandom_range(0, 2);
         len = (burst == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
         a = (64'($urandom_range(0, DEPTH - 1)) << 3) | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) a = {32'($urandom), 32'($urandom)} | 64'h8000;
         if ($urandom_range(0, 7) == 0) burst = 3;
         if ($urandom_range(0, 1) == 1) begin
            d = {};
            for (int j = 0; j <= len; j++) d.push_back({32'($urandom), 32'($urandom)});
            do_write(a, len, burst, d);
         end else begin
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len) : -1;
            do_read(a, len, burst, stall, -1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 64, beat width in bits.
- ADDR_WIDTH, default 64, address width in bits.
- MEM_WORDS_LOG, default 12, log2 of backing-store depth in beats.
- READ_LATENCY, default 2, cycles from AR handshake to first rvalid (minimum 1).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, asynchronous active-low reset.
- m_axi_awaddr/awlen/awsize/awburst/awvalid, in, ADDR_WIDTH/8/3/2/1, write address channel.
- m_axi_awready, out, 1, write address accepted.
- m_axi_wdata/wlast/wvalid, in, DATA_WIDTH/1/1, write data channel; full-beat writes, no strobes.
- m_axi_wready, out, 1, write beat accepted.
- m_axi_bresp/bvalid, out, 2/1, write response.
- m_axi_bready, in, 1, response accepted.
- m_axi_araddr/arlen/arsize/arburst/arvalid, in, ADDR_WIDTH/8/3/2/1, read address channel.
- m_axi_arready, out, 1, read address accepted.
- m_axi_rdata/rresp/rlast/rvalid, out, DATA_WIDTH/2/1/1, read data channel.
- m_axi_rready, in, 1, read beat accepted.
- m_axi_acvalid/acaddr/acsnoop, out, 1/ADDR_WIDTH/4, snoop channel, tied to 0.
- m_axi_acready, in, 1, ignored.
REQ-003 awlock/awcache/awprot/arlock/arcache/arprot SHALL be accepted as inputs and ignored; awsize/arsize SHALL be ignored, with every beat treated as DATA_WIDTH/8 bytes.

Function
REQ-004 The state machine SHALL use the states IDLE, R_WAIT, R_BURST, W_DATA and W_RESP, with one transaction outstanding at a time.
REQ-005 awready and arready SHALL be 1 only in IDLE; if awvalid and arvalid are both high in IDLE, only the write SHALL be accepted.
REQ-006 An AW handshake SHALL latch addr/len/burst, clear the beat counter and go to W_DATA; an AR handshake SHALL do the same and go to R_WAIT.
REQ-007 R_WAIT SHALL count READ_LATENCY-1 cycles and then enter R_BURST, so the first rvalid appears exactly READ_LATENCY cycles after the AR handshake.
REQ-008 In R_BURST: rvalid=1; rdata/rresp/rlast SHALL be held stable while rready=0; each rvalid&&rready SHALL advance the beat address; rlast=1 on beat len; the rlast handshake SHALL return to IDLE.
REQ-009 In W_DATA: wready=1; each wvalid&&wready SHALL write wdata to the current beat address and advance it; beats after beat len SHALL be accepted and discarded; the wlast handshake SHALL go to W_RESP.
REQ-010 In W_RESP: bvalid=1 until bready; then go to IDLE.
REQ-011 bresp SHALL be SLVERR (2'b10) if wlast arrived on a beat other than beat len, DECERR per REQ-013, otherwise OKAY (2'b00).
REQ-012 Beat address rules (beat index = addr >> log2(DATA_WIDTH/8)):
- FIXED (00): index constant.
- INCR (01): index+1.
- WRAP (10): index wraps within an aligned block of len+1 beats.
- WRAP with len+1 not in {2,4,8,16}, or burst 11: every beat SLVERR, rdata 0, writes suppressed.
REQ-013 Any start beat index >= 2**MEM_WORDS_LOG SHALL give DECERR (2'b11) on every beat, rdata 0, writes suppressed; INCR beats past the top SHALL wrap modulo 2**MEM_WORDS_LOG.
REQ-014 Reads SHALL observe all completed prior writes; memory contents are undefined at power-up.

Reset
REQ-015 While reset=0, all outputs SHALL be 0, the state SHALL be IDLE and counters 0, with memory contents preserved.
REQ-016 Reset asserted mid-burst SHALL abort the transaction immediately with no further response, and awready/arready SHALL be 1 in the first cycle after release.

Structure
REQ-017 Package axi_pkg SHALL hold the burst enum (FIXED, INCR, WRAP), the response constants (OKAY, SLVERR, DECERR) and the state enum.
REQ-018 Sub-module axi_burst_addr SHALL be purely combinational next-beat-index logic (current index, len, burst -> next index, error flag); the memory array stays in the top level.

Verification
REQ-019 Directed scenarios the bench SHALL cover:
- WRAP read, araddr=0x48, len=7, READ_LATENCY=2 -> first rvalid 2 cycles after AR; indices 9,10,11,12,13,14,15,8; rlast on beat 8; rresp OKAY.
- INCR write of 4 beats A0..A3 at 0x100 with wlast on beat 4, then INCR read of the same 4 beats -> bresp OKAY; rdata A0..A3.
- awvalid and arvalid asserted in the same IDLE cycle -> awready=1, arready=0; read accepted only after bvalid&&bready.
- rready held low for 3 cycles mid-burst -> rdata, rlast and rvalid unchanged across the stall; no beat skipped.
- wlast on beat 3 of a len=7 write, and araddr beyond 2**MEM_WORDS_LOG beats -> bresp SLVERR; read gives 8 beats of rresp DECERR with rdata 0.
- reset=0 pulsed during beat 4 of an 8-beat read -> rvalid 0 asynchronously; arready=1 in the first cycle after release; no stale beats afterwards.
